// File: rtl/e6_s4_pkg.sv
// Shared types for the e6_s4 flagged bit memory.
// A read word pairs the "ever written" flag with the stored bit.
package e6_s4_pkg;

  localparam int ADDR_W_DEF = 2;

  typedef struct packed {
    logic written;
    logic data;
  } word_t;

endpackage

// File: rtl/e6_s4_cell.sv
// One storage bit plus its sticky written flag.
// Both clear only on reset.
module e6_s4_cell (
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  logic d,
  output logic data,
  output logic written
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data    <= 1'b0;
      written <= 1'b0;
    end else if (we) begin
      data    <= d;
      written <= 1'b1;
    end
  end

endmodule

// File: rtl/e6_s4.sv
// Bit-wide scratch memory with a per-word written flag.
// The read is registered; during a write, Dout shows the value being written.
module e6_s4
  import e6_s4_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic              Din,
  input  logic              WR,
  output logic [1:0]        Dout
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] data_vec;
  logic [DEPTH-1:0] written_vec;
  word_t            rd_word;

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    e6_s4_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .we      (WR && (address == ADDR_W'(i))),
      .d       (Din),
      .data    (data_vec[i]),
      .written (written_vec[i])
    );
  end

  always_comb begin
    rd_word = '0;
    if (WR) begin
      rd_word.written = 1'b1;
      rd_word.data    = Din;
    end else begin
      rd_word.written = written_vec[address];
      rd_word.data    = data_vec[address];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) Dout <= 2'b00;
    else     Dout <= rd_word;
  end

endmodule

// File: tb/tb_e6_s4.sv
// Randomized bench for e6_s4 against a "stored value or never written" model.
// Directed cases first, then random reads, writes and reset pulses.
module tb_e6_s4;

  logic       clk;
  logic       rst;
  logic [1:0] address;
  logic       Din;
  logic       WR;
  logic [1:0] Dout;

  int passed;
  int total;

  // -1 means never written since reset, otherwise the stored bit
  int model [4];

  e6_s4 #(.ADDR_W(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .address (address),
    .Din     (Din),
    .WR      (WR),
    .Dout    (Dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  function automatic logic [1:0] model_read(input int a);
    if (model[a] < 0) return 2'b00;
    return {1'b1, model[a][0]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) model[i] = -1;
  endtask

  // Called at posedge+1; drives one operation and checks Dout after the next edge.
  task automatic op(input string tag, input int a, input logic w, input logic d);
    logic [1:0] exp;
    address = 2'(a);
    WR      = w;
    Din     = d;
    if (w) begin
      exp      = {1'b1, d};
      model[a] = int'(d);
    end else begin
      exp = model_read(a);
    end
    @(posedge clk);
    #1;
    chk(tag, Dout, exp);
  endtask

  // Pulse reset between edges and check Dout drops without a clock edge.
  task automatic reset_pulse(input string tag);
    WR  = 1'b0;
    rst = 1'b1;
    #2;
    chk(tag, Dout, 2'b00);
    rst = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  initial begin
    passed  = 0;
    total   = 0;
    rst     = 1'b1;
    address = '0;
    Din     = 1'b0;
    WR      = 1'b0;
    model_clear();

    // Reset held across edges with a write pending: write must be lost.
    WR = 1'b1; Din = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", Dout, 2'b00);
    WR  = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) op("reset_read", i, 1'b0, 1'b0);

    // Write sweep, then readback
    op("sweep_w0", 0, 1'b1, 1'b0);
    op("sweep_w1", 1, 1'b1, 1'b1);
    op("sweep_w2", 2, 1'b1, 1'b0);
    op("sweep_w3", 3, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) op("readback", i, 1'b0, 1'b0);

    // Overwrite keeps flag
    op("ovr_w1", 1, 1'b1, 1'b0);
    op("ovr_r1", 1, 1'b0, 1'b0);
    op("ovr_r3", 3, 1'b0, 1'b0);

    // Reset mid-operation clears everything
    reset_pulse("mid_reset_async");
    for (int i = 0; i < 4; i++) op("mid_reset_read", i, 1'b0, 1'b0);

    // Partial fill
    op("partial_w2", 2, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) op("partial_read", i, 1'b0, 1'b0);

    // Random traffic with occasional reset pulses
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 39) == 0)
        reset_pulse("rand_reset");
      else
        op("rand_op", int'($urandom_range(0, 3)), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
